// File: rtl/bus_grant_scheduler_pkg.sv
// Shared arbitration types and helpers for the node-local bus schedulers and bus muxes.
package bus_grant_scheduler_pkg;

  localparam int unsigned ARB_MAX_N = 16;
  localparam int unsigned ARB_IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // OR-reduction encoder; exact for one-hot or all-zero input.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_index(input logic [ARB_MAX_N-1:0] bgnt);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (bgnt[i]) idx = idx | ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_grant_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible request after last, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N       = 2,
  parameter int unsigned OWNER_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]       req_i,
  input  logic [N-1:0]       mask_i,
  input  logic [OWNER_W-1:0] last_i,
  output logic [N-1:0]       winner_o,
  output logic               valid_o
);

  logic [N-1:0]   elig;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [OWNER_W:0] shamt;
  int pos;
  int idx;

  assign elig  = req_i & ~mask_i;
  assign dbl   = {elig, elig};
  assign shamt = (OWNER_W+1)'(last_i) + (OWNER_W+1)'(1);
  assign rot   = N'(dbl >> shamt);

  // Lowest set bit of the rotated vector, mapped back to a requester index.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    pos      = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        pos     = j;
        valid_o = 1'b1;
      end
    end
    idx = int'(shamt) + pos;
    if (idx >= int'(N)) idx = idx - int'(N);
    for (int k = 0; k < N; k++) begin
      winner_o[k] = valid_o && (idx == k);
    end
  end

endmodule

// File: rtl/bus_grant_scheduler.sv
// Round-robin bus grant scheduler with registered one-hot grant and optional tenure watchdog.
module bus_grant_scheduler
  import bus_grant_scheduler_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter int unsigned MAX_HOLD = 0,
  localparam int unsigned OWNER_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       breq,
  input  logic               bhold,
  output logic [N-1:0]       bgnt,
  output logic               busy,
  output logic [OWNER_W-1:0] owner,
  output logic               timeout,
  output logic [OWNER_W-1:0] timeout_id
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [N-1:0]       bgnt_q, bgnt_d;
  logic               busy_q, busy_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] last_q, last_d;
  logic               timeout_q, timeout_d;
  logic [OWNER_W-1:0] timeout_id_q, timeout_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  arb_state_e         st_c;
  logic               cont_c;
  logic               force_c;
  logic [N-1:0]       win_c;
  logic               win_vld_c;
  logic [OWNER_W-1:0] win_idx_c;

  // The current owner is always masked so a forced release cannot re-grant it.
  rr_pick #(.N(N), .OWNER_W(OWNER_W)) u_pick (
    .req_i    (breq),
    .mask_i   (bgnt_q),
    .last_i   (last_q),
    .winner_o (win_c),
    .valid_o  (win_vld_c)
  );

  assign win_idx_c = OWNER_W'(onehot_to_index(ARB_MAX_N'(win_c)));
  assign st_c      = (bgnt_q != '0) ? ST_GRANT : ST_IDLE;
  assign cont_c    = (st_c == ST_GRANT) && ((|(breq & bgnt_q)) || bhold);
  assign force_c   = (MAX_HOLD != 0) && cont_c && (cnt_q == CNT_W'(MAX_HOLD - 1));

  // Hold the tenure, or hand the bus to the next winner (or idle) on release/eviction.
  always_comb begin
    bgnt_d       = bgnt_q;
    busy_d       = busy_q;
    owner_d      = owner_q;
    last_d       = last_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    cnt_d        = cnt_q;
    if (cont_c && !force_c) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d   = '0;
      bgnt_d  = win_vld_c ? win_c : '0;
      busy_d  = win_vld_c;
      owner_d = win_vld_c ? win_idx_c : '0;
      if (win_vld_c) last_d = win_idx_c;
      if (force_c) begin
        timeout_d    = 1'b1;
        timeout_id_d = owner_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bgnt_q       <= '0;
      busy_q       <= 1'b0;
      owner_q      <= '0;
      last_q       <= OWNER_W'(N - 1);
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
      cnt_q        <= '0;
    end else begin
      bgnt_q       <= bgnt_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bgnt       = bgnt_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Scoreboard bench: five scheduler configurations driven by directed vectors.
module tb_bus_grant_scheduler;

  logic clock;
  logic reset;

  logic [2:0] breq_a; logic bh_a; logic [2:0] bgnt_a; logic busy_a; logic [1:0] own_a; logic to_a; logic [1:0] tid_a;
  logic [1:0] breq_b; logic bh_b; logic [1:0] bgnt_b; logic busy_b; logic [0:0] own_b; logic to_b; logic [0:0] tid_b;
  logic [1:0] breq_c; logic bh_c; logic [1:0] bgnt_c; logic busy_c; logic [0:0] own_c; logic to_c; logic [0:0] tid_c;
  logic [0:0] breq_d; logic bh_d; logic [0:0] bgnt_d; logic busy_d; logic [0:0] own_d; logic to_d; logic [0:0] tid_d;
  logic [3:0] breq_e; logic bh_e; logic [3:0] bgnt_e; logic busy_e; logic [1:0] own_e; logic to_e; logic [1:0] tid_e;

  bus_grant_scheduler #(.N(3), .MAX_HOLD(0)) u_a (.clock(clock), .reset(reset), .breq(breq_a), .bhold(bh_a),
    .bgnt(bgnt_a), .busy(busy_a), .owner(own_a), .timeout(to_a), .timeout_id(tid_a));
  bus_grant_scheduler #(.N(2), .MAX_HOLD(0)) u_b (.clock(clock), .reset(reset), .breq(breq_b), .bhold(bh_b),
    .bgnt(bgnt_b), .busy(busy_b), .owner(own_b), .timeout(to_b), .timeout_id(tid_b));
  bus_grant_scheduler #(.N(2), .MAX_HOLD(8)) u_c (.clock(clock), .reset(reset), .breq(breq_c), .bhold(bh_c),
    .bgnt(bgnt_c), .busy(busy_c), .owner(own_c), .timeout(to_c), .timeout_id(tid_c));
  bus_grant_scheduler #(.N(1), .MAX_HOLD(4)) u_d (.clock(clock), .reset(reset), .breq(breq_d), .bhold(bh_d),
    .bgnt(bgnt_d), .busy(busy_d), .owner(own_d), .timeout(to_d), .timeout_id(tid_d));
  bus_grant_scheduler #(.N(4), .MAX_HOLD(0)) u_e (.clock(clock), .reset(reset), .breq(breq_e), .bhold(bh_e),
    .bgnt(bgnt_e), .busy(busy_e), .owner(own_e), .timeout(to_e), .timeout_id(tid_e));

  logic [31:0] act_a, act_b, act_c, act_d, act_e;
  assign act_a = {6'b0, 4'(tid_a), to_a, 4'(own_a), busy_a, 16'(bgnt_a)};
  assign act_b = {6'b0, 4'(tid_b), to_b, 4'(own_b), busy_b, 16'(bgnt_b)};
  assign act_c = {6'b0, 4'(tid_c), to_c, 4'(own_c), busy_c, 16'(bgnt_c)};
  assign act_d = {6'b0, 4'(tid_d), to_d, 4'(own_d), busy_d, 16'(bgnt_d)};
  assign act_e = {6'b0, 4'(tid_e), to_e, 4'(own_e), busy_e, 16'(bgnt_e)};

  logic [31:0] q_a[$], q_b[$], q_c[$], q_d[$], q_e[$];
  int total = 0;
  int bad   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ex(input logic [15:0] g, input int o, input logic to, input int tid);
    return {6'b0, 4'(tid), to, 4'(o), (g != 16'h0), g};
  endfunction

  task automatic chk(input string nm, input logic [31:0] e, input logic [31:0] a);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t act(tid,to,own,busy,gnt)=%h exp=%h", nm, $time, a, e);
    end
  endtask

  // Monitor: each negedge, compare any pending expectation against the outputs.
  always @(negedge clock) begin
    if (q_a.size() > 0) chk("n3_rr", q_a.pop_front(), act_a);
    if (q_b.size() > 0) chk("n2_hold", q_b.pop_front(), act_b);
    if (q_c.size() > 0) chk("n2_wdog8", q_c.pop_front(), act_c);
    if (q_d.size() > 0) chk("n1_wdog4", q_d.pop_front(), act_d);
    if (q_e.size() > 0) chk("n4_reset", q_e.pop_front(), act_e);
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input int d, input logic [15:0] r, input logic bh, input logic [31:0] e);
    @(negedge clock);
    #1;
    case (d)
      0: begin breq_a = 3'(r); bh_a = bh; q_a.push_back(e); end
      1: begin breq_b = 2'(r); bh_b = bh; q_b.push_back(e); end
      2: begin breq_c = 2'(r); bh_c = bh; q_c.push_back(e); end
      3: begin breq_d = 1'(r); bh_d = bh; q_d.push_back(e); end
      default: begin breq_e = 4'(r); bh_e = bh; q_e.push_back(e); end
    endcase
  endtask

  initial begin
    int own;
    int tid;
    int guard;
    reset  = 1'b0;
    breq_a = '0; bh_a = 1'b0; breq_b = '0; bh_b = 1'b0; breq_c = '0; bh_c = 1'b0;
    breq_d = '0; bh_d = 1'b0; breq_e = '0; bh_e = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_a", ex(0, 0, 0, 0), act_a);
    chk("rst_b", ex(0, 0, 0, 0), act_b);
    chk("rst_c", ex(0, 0, 0, 0), act_c);
    chk("rst_d", ex(0, 0, 0, 0), act_d);
    chk("rst_e", ex(0, 0, 0, 0), act_e);
    #1 reset = 1'b1;

    // N=3 strict rotation, no idle cycles between owners.
    step(0, 16'b111, 0, ex(16'b001, 0, 0, 0));
    step(0, 16'b111, 0, ex(16'b001, 0, 0, 0));
    step(0, 16'b110, 0, ex(16'b010, 1, 0, 0));
    step(0, 16'b101, 0, ex(16'b100, 2, 0, 0));
    step(0, 16'b011, 0, ex(16'b001, 0, 0, 0));
    step(0, 16'b000, 0, ex(16'b000, 0, 0, 0));
    step(0, 16'b000, 0, ex(16'b000, 0, 0, 0));

    // N=2 bhold extends a one-cycle request to five grant cycles.
    step(1, 16'b10, 0, ex(16'b10, 1, 0, 0));
    repeat (4) step(1, 16'b00, 1, ex(16'b10, 1, 0, 0));
    step(1, 16'b00, 0, ex(16'b00, 0, 0, 0));
    // Owner 0 releases as requester 1 rises: direct handover.
    step(1, 16'b01, 0, ex(16'b01, 0, 0, 0));
    step(1, 16'b01, 0, ex(16'b01, 0, 0, 0));
    step(1, 16'b10, 0, ex(16'b10, 1, 0, 0));
    step(1, 16'b00, 0, ex(16'b00, 0, 0, 0));

    // MAX_HOLD=8: forced alternation every 8 cycles with timeout pulses.
    own = 0;
    tid = 0;
    step(2, 16'b11, 0, ex(16'b01, 0, 0, 0));
    for (int r = 0; r < 3; r++) begin
      repeat (7) step(2, 16'b11, 0, ex((own != 0) ? 16'b10 : 16'b01, own, 0, tid));
      tid = own;
      own = 1 - own;
      step(2, 16'b11, 0, ex((own != 0) ? 16'b10 : 16'b01, own, 1, tid));
    end
    step(2, 16'b00, 0, ex(16'b00, 0, 0, tid));

    // N=1 MAX_HOLD=4: four grant cycles, one idle cycle with timeout, re-grant.
    repeat (2) begin
      step(3, 16'b1, 0, ex(16'b1, 0, 0, 0));
      repeat (3) step(3, 16'b1, 0, ex(16'b1, 0, 0, 0));
      step(3, 16'b1, 0, ex(16'b0, 0, 1, 0));
    end
    step(3, 16'b0, 0, ex(16'b0, 0, 0, 0));

    // N=4: asynchronous reset mid-tenure, then pointer restarts at N-1.
    step(4, 16'b0100, 0, ex(16'b0100, 2, 0, 0));
    step(4, 16'b0000, 1, ex(16'b0100, 2, 0, 0));
    @(negedge clock);
    #2 reset = 1'b0;
    #1 chk("async_rst", ex(0, 0, 0, 0), act_e);
    bh_e = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    step(4, 16'b1100, 0, ex(16'b0100, 2, 0, 0));
    step(4, 16'b1100, 0, ex(16'b0100, 2, 0, 0));
    step(4, 16'b1000, 0, ex(16'b1000, 3, 0, 0));
    step(4, 16'b0000, 0, ex(16'b0000, 0, 0, 0));

    guard = 0;
    while ((q_a.size() + q_b.size() + q_c.size() + q_d.size() + q_e.size()) != 0 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    #1;
    total++;
    if ((q_a.size() + q_b.size() + q_c.size() + q_d.size() + q_e.size()) != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0",
               q_a.size() + q_b.size() + q_c.size() + q_d.size() + q_e.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
